// File: rtl/aes_pkg.sv
// Shared AES constants and helpers for the key-schedule blocks: last-round Rcon,
// inverse xtime, word/byte selection and the key-schedule FSM encoding.
package aes_pkg;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_key_t;

  localparam logic [7:0] AES_RCON_LAST = 8'h36;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESENT = 2'd1;
  localparam logic [1:0] ST_COMPUTE = 2'd2;

  // Steps Rcon backwards: 36,1B,80,40,...,01.
  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    return x[0] ? ((x >> 1) ^ 8'h8D) : (x >> 1);
  endfunction

  function automatic aes_word_t get_word(input aes_key_t k, input logic [1:0] i);
    return k[32*i +: 32];
  endfunction

  // FIPS byte 0 sits in the MSB of a word.
  function automatic logic [7:0] word_byte(input aes_word_t w, input logic [1:0] b);
    return w[8*(2'd3 - b) +: 8];
  endfunction

  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational; shared with expand_key.
module aes_sbox (
  input  logic [7:0] byte_val,
  output logic [7:0] sub_val
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign sub_val = SBOX[byte_val];

endmodule

// File: rtl/inv_expand_key.sv
// Reverse AES-128 key schedule: emits round keys LAST_ROUND..0 over valid/ready.
// INV_EXPAND_KEY_SHARED_SBOX_EN selects one time-shared S-box (4-cycle COMPUTE).
module inv_expand_key
  import aes_pkg::*;
#(
  parameter int LAST_ROUND = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [127:0] key_out,
  output logic [3:0]   round_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);

  logic [1:0]  state_reg;
  aes_key_t    key_reg;
  logic [3:0]  round_reg;
  logic [7:0]  rcon_reg;
  logic        busy_reg;
  logic        done_reg;

  aes_word_t   a0, a1, a2, a3;
  aes_word_t   b0, b1, b2, b3;
  aes_word_t   rot;
  aes_word_t   sub_word;
  aes_key_t    prev_key;
  logic        compute_last;

  assign a0 = get_word(key_reg, 2'd0);
  assign a1 = get_word(key_reg, 2'd1);
  assign a2 = get_word(key_reg, 2'd2);
  assign a3 = get_word(key_reg, 2'd3);

  // Undo the forward XOR chain; w[4i] needs SubWord of the recovered w[4i-1].
  assign b3  = a3 ^ a2;
  assign b2  = a2 ^ a1;
  assign b1  = a1 ^ a0;
  assign rot = rot_word(b3);
  assign b0  = a0 ^ sub_word ^ {rcon_reg, 24'h0};
  assign prev_key = {b3, b2, b1, b0};

`ifdef INV_EXPAND_KEY_SHARED_SBOX_EN
  logic [1:0]  cnt_reg;
  aes_word_t   tmp_reg;
  logic [7:0]  sub_byte;

  aes_sbox u_sbox (
    .byte_val (word_byte(rot, cnt_reg)),
    .sub_val  (sub_byte)
  );

  // Bytes from earlier cycles come from tmp_reg; the current byte is merged live.
  always_comb begin
    sub_word = tmp_reg;
    sub_word[8*(2'd3 - cnt_reg) +: 8] = sub_byte;
  end

  assign compute_last = (cnt_reg == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
      tmp_reg <= '0;
    end else if (state_reg == ST_COMPUTE) begin
      cnt_reg <= cnt_reg + 2'd1;
      tmp_reg <= sub_word;
    end else begin
      cnt_reg <= '0;
    end
  end
`else
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      aes_sbox u_sbox (
        .byte_val (word_byte(rot, 2'(gi))),
        .sub_val  (sub_word[8*(3-gi) +: 8])
      );
    end
  endgenerate

  assign compute_last = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      key_reg   <= '0;
      round_reg <= '0;
      rcon_reg  <= AES_RCON_LAST;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            key_reg   <= key_in;
            round_reg <= LAST_ROUND[3:0];
            rcon_reg  <= AES_RCON_LAST;
            busy_reg  <= 1'b1;
            state_reg <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (out_ready) begin
            if (round_reg == 4'd0) begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= ST_IDLE;
            end else begin
              state_reg <= ST_COMPUTE;
            end
          end
        end
        ST_COMPUTE: begin
          if (compute_last) begin
            key_reg   <= prev_key;
            round_reg <= round_reg - 4'd1;
            rcon_reg  <= inv_xtime(rcon_reg);
            state_reg <= ST_PRESENT;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign key_out   = key_reg;
  assign round_out = round_reg;
  assign out_valid = (state_reg == ST_PRESENT);
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_inv_expand_key.sv
// Bench for inv_expand_key: forward-schedule scoreboard plus FIPS-197 spot vectors.
module tb_inv_expand_key;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] key_in = '0;
  logic [127:0] key_out;
  logic [3:0]   round_out;
  logic         out_valid;
  logic         busy;
  logic         done;

  inv_expand_key dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .key_out   (key_out),
    .round_out (round_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

`ifdef INV_EXPAND_KEY_SHARED_SBOX_EN
  localparam int GAP = 5;
`else
  localparam int GAP = 2;
`endif

  localparam logic [7:0] SB [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] key;
  } exp_t;

  typedef struct {
    logic [127:0] key0;
    int           rnd;
    logic [127:0] expect_key;
  } vec_t;

  int           vectors = 0;
  int           miscompares = 0;
  exp_t         sb_q[$];
  logic [127:0] sched [0:10];
  logic [127:0] got [0:10];
  int           hs_count = 0;
  int           done_count = 0;
  int           cyc = 0;
  int           hs_cyc = 0;
  bit           gap_pending = 1'b0;
  vec_t         tbl [6];

  // FIPS hex string order (byte 0 leftmost) to the packed word layout.
  function automatic logic [127:0] fips(input logic [127:0] x);
    return {x[31:0], x[63:32], x[95:64], x[127:96]};
  endfunction

  task automatic check_k(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic check_n(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Forward key expansion, the reference the reverse schedule must reproduce.
  task automatic compute_sched(input logic [127:0] k0);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k0[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {SB[t[31:24]], SB[t[23:16]], SB[t[15:8]], SB[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) sched[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (gap_pending && out_valid && cyc != hs_cyc) begin
      gap_pending = 1'b0;
      check_n("hs_to_valid_gap", cyc - hs_cyc, GAP);
    end
    if (out_valid && out_ready) begin
      hs_count++;
      hs_cyc = cyc;
      gap_pending = 1'b1;
      if (round_out <= 4'd10) got[round_out] = key_out;
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_handshake: round %0d key %h with nothing expected", round_out, key_out);
      end else begin
        e = sb_q.pop_front();
        check_n("round_out", int'(round_out), int'(e.rnd));
        check_k($sformatf("key_out_r%0d", e.rnd), key_out, e.key);
      end
    end
    if (done) begin
      done_count++;
      check_n("busy_at_done", int'(busy), 0);
    end
  end

  task automatic start_run(input logic [127:0] k0);
    compute_sched(k0);
    sb_q.delete();
    for (int r = 10; r >= 0; r--) sb_q.push_back('{rnd: 4'(r), key: sched[r]});
    for (int r = 0; r <= 10; r++) got[r] = '0;
    hs_count = 0;
    done_count = 0;
    gap_pending = 1'b0;
    @(posedge clk); #1;
    key_in = sched[10];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_n("busy_after_start", int'(busy), 1);
    $display("run started: key0 %h key10 %h", k0, sched[10]);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_count == 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_count == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: no done after %0d cycles", name, n);
    end
    repeat (3) @(posedge clk);
    #1;
    check_n({name, "_handshakes"}, hs_count, 11);
    check_n({name, "_done_pulses"}, done_count, 1);
    check_n({name, "_queue_left"}, sb_q.size(), 0);
  endtask

  task automatic wait_present(input int r, input string name);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    while (n < 300) begin
      if (out_valid && int'(round_out) == r) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: round %0d never presented (round_out %0d)", name, r, round_out);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish (vectors %0d)", vectors);
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] last_k0;
    logic [127:0] k_bp;
    logic [127:0] k_ign;
    logic [127:0] k_ab;
    logic [127:0] snap_key;
    logic [3:0]   snap_round;
    int           n;

    tbl[0] = '{key0: fips(128'h2b7e151628aed2a6abf7158809cf4f3c), rnd: 10,
               expect_key: fips(128'hd014f9a8c9ee2589e13f0cc8b6630ca6)};
    tbl[1] = '{key0: fips(128'h2b7e151628aed2a6abf7158809cf4f3c), rnd: 9,
               expect_key: fips(128'hac7766f319fadc2128d12941575c006e)};
    tbl[2] = '{key0: fips(128'h2b7e151628aed2a6abf7158809cf4f3c), rnd: 1,
               expect_key: fips(128'ha0fafe1788542cb123a339392a6c7605)};
    tbl[3] = '{key0: fips(128'h2b7e151628aed2a6abf7158809cf4f3c), rnd: 0,
               expect_key: fips(128'h2b7e151628aed2a6abf7158809cf4f3c)};
    tbl[4] = '{key0: 128'h0c0d0e0f08090a0b0405060700010203, rnd: 10,
               expect_key: fips(128'h13111d7fe3944a17f307a78b4d2b30c5)};
    tbl[5] = '{key0: 128'h0c0d0e0f08090a0b0405060700010203, rnd: 0,
               expect_key: 128'h0c0d0e0f08090a0b0405060700010203};

    #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_k("rst_key_out", key_out, '0);
    check_n("rst_round_out", int'(round_out), 0);
    check_n("rst_out_valid", int'(out_valid), 0);
    check_n("rst_busy", int'(busy), 0);
    check_n("rst_done", int'(done), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Table vectors: each new key0 triggers a full run, then spot rounds are compared.
    last_k0 = '1;
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].key0 !== last_k0) begin
        start_run(tbl[i].key0);
        wait_done($sformatf("tbl%0d", i));
        last_k0 = tbl[i].key0;
      end
      check_k($sformatf("tbl%0d_round%0d", i, tbl[i].rnd), got[tbl[i].rnd], tbl[i].expect_key);
    end

    // Backpressure at round 5.
    k_bp = {$urandom, $urandom, $urandom, $urandom};
    start_run(k_bp);
    wait_present(5, "bp");
    out_ready = 1'b0;
    snap_key = key_out;
    snap_round = round_out;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      check_k($sformatf("bp_key_hold%0d", c), key_out, snap_key);
      check_n($sformatf("bp_round_hold%0d", c), int'(round_out), int'(snap_round));
      check_n($sformatf("bp_valid_hold%0d", c), int'(out_valid), 1);
    end
    out_ready = 1'b1;
    wait_done("bp");

    // Start while busy (round 6) and start coincident with the final handshake.
    k_ign = {$urandom, $urandom, $urandom, $urandom};
    start_run(k_ign);
    wait_present(6, "ign6");
    key_in = ~key_in;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_n("ign_busy_held", int'(busy), 1);
    wait_present(0, "ign0");
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ign");
    check_n("ign_final_valid", int'(out_valid), 0);
    check_n("ign_final_busy", int'(busy), 0);
    check_n("ign_final_round", int'(round_out), 0);

    // Asynchronous abort during COMPUTE after round 3, then a clean restart.
    k_ab = {$urandom, $urandom, $urandom, $urandom};
    start_run(k_ab);
    n = 0;
    while (!(busy && !out_valid && round_out == 4'd3) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check_n("abort_reached_compute_r3", int'(round_out), 3);
    #2 rst = 1'b0;
    #1;
    check_k("abort_key_out", key_out, '0);
    check_n("abort_round_out", int'(round_out), 0);
    check_n("abort_out_valid", int'(out_valid), 0);
    check_n("abort_busy", int'(busy), 0);
    check_n("abort_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1;
    check_n("abort_no_done", done_count, 0);
    check_n("abort_handshakes", hs_count, 8);
    sb_q.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    start_run(k_ab);
    wait_done("restart");
    check_k("restart_round0", got[0], k_ab);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inv_expand_key.md
Name: inv_expand_key

Overview:
- Reverse AES-128 key schedule for the decryption datapath.
- Accepts the round-10 key and emits round keys in descending order, 10 down to 0, one at a time over a valid/ready handshake.
- Sits beside expand_key and feeds the inverse-cipher round logic.
- Removes the need to store all 11 forward round keys.

Parameters:
- LAST_ROUND, 10, index of the first key emitted; Rcon for that round is 8'h36 (rounds 9..1 use the inverse-xtime chain).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  1-cycle request; sampled only in IDLE
- key_in  in  128  round-LAST_ROUND key
- key_out  out  128  current round key
- round_out  out  4  round index of key_out
- out_valid  out  1  key_out/round_out valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- busy  out  1  high from start acceptance until the final handshake
- done  out  1  1-cycle pulse after the round-0 handshake

Behaviour:
- Packing, same as expand_key:
  - word i lives at [32i+31:32i].
  - Within a word, FIPS byte 0 is the MSB.
  - FIPS key 000102..0f packs as 128'h0c0d0e0f08090a0b0405060700010203.
- Reset (rst=0, asynchronous) forces:
  - outputs: key_out=0, round_out=0, out_valid=0, busy=0, done=0;
  - state: IDLE, rcon register=8'h36.
  - Reset asserted mid-operation aborts immediately. No done is produced.
- States:
  - IDLE: start=1 → latch key_in, round=LAST_ROUND, rcon=8'h36, go to PRESENT. busy=1 on the next cycle.
  - PRESENT: out_valid=1, outputs held stable.
    - Handshake with round>0 → go to COMPUTE.
    - Handshake with round==0 → go to IDLE, done=1 for one cycle, busy=0.
    - out_ready low → hold indefinitely.
  - COMPUTE: out_valid=0. Calculate the previous key from the current key (a0..a3):
    - b3=a3^a2, b2=a2^a1, b1=a1^a0;
    - b0=a0^SubWord(RotWord(b3))^{rcon,24'h0}.
    - Then round←round-1, rcon←inv_xtime(rcon), go to PRESENT.
    - Default latency: 1 cycle, so successive handshakes are at best 2 cycles apart.
- inv_xtime(x) = x[0] ? (x>>1)^8'h8D : x>>1. Sequence: 36,1B,80,40,20,10,08,04,02,01.
- start while busy is ignored.
- start and the final handshake in the same cycle: start is ignored, since the FSM is not yet in IDLE.
- round_out never underflows: round 0 is terminal.

Optional Feature:
- Macro: INV_EXPAND_KEY_SHARED_SBOX_EN.
- Defined:
  - One S-box instance is time-multiplexed over the 4 bytes of RotWord(b3).
  - COMPUTE lasts exactly 4 cycles, one byte per cycle via a 2-bit counter, with b0 assembled in a temp register.
  - All other timing and handshake behaviour is unchanged.
- Undefined: 4 parallel S-boxes, COMPUTE lasts 1 cycle.

Decomposition:
- Shared package aes_pkg holds:
  - AES_RCON_LAST (8'h36);
  - the inv_xtime function;
  - the word/byte index helpers;
  - FSM state encoding IDLE/PRESENT/COMPUTE.
- Sub-module aes_sbox: 8-bit forward S-box, combinational. It is reused by expand_key; instantiate 4 copies, or 1 with the feature.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
  - key_in = round-10 key d014f9a8c9ee2589e13f0cc8b6630ca6 (packed);
  - out_ready=1;
  - expect round 9 = ac7766f319fadc2128d12941575c006e, round 1 = a0fafe1788542cb123a339392a6c7605, round 0 = original key;
  - done pulses once, busy drops in the same cycle.
- Key 000102..0f:
  - key_in = round-10 key 13111d7fe3944a17f307a78b4d2b30c5;
  - expect round 0 = 128'h0c0d0e0f08090a0b0405060700010203 packed.
  - Cross-check each round against expand_key's forward output.
- Backpressure:
  - hold out_ready=0 for 7 cycles at round 5;
  - key_out/round_out stay stable, no skipped or duplicated round;
  - total handshakes = 11.
- Pulse start at round 6 with a different key_in: ignored, sequence and values unchanged.
- Drop rst mid-COMPUTE at round 3:
  - all outputs 0 asynchronously, no done;
  - a restart then produces the full correct sequence.
- With INV_EXPAND_KEY_SHARED_SBOX_EN:
  - same vectors as the first scenario;
  - handshake-to-next-out_valid gap is exactly 5 cycles;
  - values are identical.
